// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Round-robin arbiter and sequencer that shares one spi_master
//               among NREQ requesters and returns the MISO byte with an ack.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int NREQ        = 3,
    parameter int DATA_W      = 8,
    parameter int NSLAVE      = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      req_slave_sel,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   spi_start,
    output logic [1:0]             spi_slave_sel,
    output logic [DATA_W-1:0]      spi_mosi_data,
    input  logic                   spi_done,
    input  logic [DATA_W-1:0]      spi_miso_data
);

    localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NREQ - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [2:0]         c_nslave   = 3'(NSLAVE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_done_q;

    logic                 w_any_req;
    logic [c_idx_w-1:0]   w_pick;
    logic [NREQ-1:0]      w_pick_oh;
    logic [1:0]           w_pick_sel;
    logic [DATA_W-1:0]    w_pick_data;
    logic                 w_sel_bad;
    logic                 w_done_rise;

    // Requester index reached by stepping 'off' positions from 'base', modulo NREQ.
    function automatic logic [c_idx_w-1:0] f_wrap(input logic [c_idx_w-1:0] base,
                                                  input int                 off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return c_idx_w'(s);
    endfunction

    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any_req && req[f_wrap(r_ptr, k)]) begin
                w_any_req = 1'b1;
                w_pick    = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_pick_oh   = NREQ'(1) << w_pick;
    assign w_pick_sel  = req_slave_sel[2*w_pick +: 2];
    assign w_pick_data = req_data[DATA_W*w_pick +: DATA_W];
    assign w_sel_bad   = ({1'b0, w_pick_sel} >= c_nslave);
    assign w_done_rise = spi_done & ~r_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_done_q      <= 1'b0;
            gnt           <= '0;
            ack           <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
            spi_start     <= 1'b0;
            spi_slave_sel <= '0;
            spi_mosi_data <= '0;
        end else begin
            r_done_q <= spi_done;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_idx <= w_pick;
                        gnt   <= w_pick_oh;
                        busy  <= 1'b1;
                        // An unreachable slave is answered with an error without touching the bus.
                        if (w_sel_bad) begin
                            ack      <= w_pick_oh;
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                            r_state  <= S_RESP;
                        end else begin
                            spi_start     <= 1'b1;
                            spi_slave_sel <= w_pick_sel;
                            spi_mosi_data <= w_pick_data;
                            r_state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    spi_start <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        ack      <= gnt;
                        rsp_data <= spi_miso_data;
                        rsp_err  <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_cnt == c_tmo_last) begin
                        ack      <= gnt;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    ack     <= '0;
                    rsp_err <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    r_ptr   <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arbiter
// Description : Directed and randomized bench for spi_arbiter with a
//               round-robin reference model and a simple SPI slave responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    localparam int c_tmo = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [5:0]  req_slave_sel;
    logic [23:0] req_data;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        spi_start;
    logic [1:0]  spi_slave_sel;
    logic [7:0]  spi_mosi_data;
    logic        spi_done;
    logic [7:0]  spi_miso_data;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    logic [7:0] slave_tx [0:2] = '{8'hA5, 8'h3C, 8'hF0};

    spi_arbiter #(
        .NREQ        (3),
        .DATA_W      (8),
        .NSLAVE      (3),
        .TIMEOUT_CYC (c_tmo)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_slave_sel (req_slave_sel),
        .req_data      (req_data),
        .gnt           (gnt),
        .ack           (ack),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .spi_start     (spi_start),
        .spi_slave_sel (spi_slave_sel),
        .spi_mosi_data (spi_mosi_data),
        .spi_done      (spi_done),
        .spi_miso_data (spi_miso_data)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Spec rule: first pending requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    // Entered with the DUT idle and req already driven; leaves it idle again.
    task automatic serve(input int idx, input int sel, input logic [7:0] data,
                         input int delay, input bit drop, input bit scramble);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        step();
        chk("grant", gnt, oh);
        chk("busy_on", busy, 1);
        if (sel >= 3) begin
            chk("inv_ack", ack, oh);
            chk("inv_err", rsp_err, 1);
            chk("inv_nostart", spi_start, 0);
            step();
            chk("inv_ack_end", ack, 0);
            chk("inv_gnt_end", gnt, 0);
            chk("inv_busy_end", busy, 0);
            mptr = (idx + 1) % 3;
            return;
        end
        chk("start", spi_start, 1);
        chk("start_sel", spi_slave_sel, sel);
        chk("start_mosi", spi_mosi_data, data);
        chk("no_early_ack", ack, 0);
        if (drop) req = 3'b000;
        if (scramble) begin
            req_data      = 24'($urandom);
            req_slave_sel = 6'($urandom);
        end
        step();
        chk("start_pulse_end", spi_start, 0);
        chk("gnt_hold", gnt, oh);
        for (int d = 0; d < delay; d++) begin
            step();
            chk("wait_no_ack", ack, 0);
            chk("wait_mosi_stable", spi_mosi_data, data);
        end
        spi_miso_data = slave_tx[sel];
        spi_done      = 1'b1;
        step();
        chk("ack", ack, oh);
        chk("rsp_data", rsp_data, slave_tx[sel]);
        chk("rsp_err", rsp_err, 0);
        chk("resp_sel_stable", spi_slave_sel, sel);
        spi_done      = 1'b0;
        spi_miso_data = 8'($urandom);
        step();
        chk("ack_end", ack, 0);
        chk("gnt_end", gnt, 0);
        chk("busy_end", busy, 0);
        chk("rsp_hold", rsp_data, slave_tx[sel]);
        mptr = (idx + 1) % 3;
    endtask

    initial begin
        int n;
        logic [2:0]  r;
        logic [5:0]  s;
        logic [23:0] dat;
        int          idx;

        rst = 1'b1;
        req = '0;
        req_slave_sel = '0;
        req_data = '0;
        spi_done = 1'b0;
        spi_miso_data = '0;
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_rsp", {rsp_err, rsp_data}, 0);
        chk("rst_spi_out", {spi_slave_sel, spi_mosi_data}, 0);
        rst = 1'b0;
        mptr = 0;
        step();
        chk("idle_busy", busy, 0);

        // Contention: all three asserted, order 0,1,2,0.
        req = 3'b111;
        req_slave_sel = 6'b10_01_00;
        req_data = 24'h33_22_11;
        serve(0, 0, 8'h11, 2, 0, 0);
        serve(1, 1, 8'h22, 0, 0, 0);
        serve(2, 2, 8'h33, 3, 0, 0);
        serve(0, 0, 8'h11, 1, 0, 0);
        req = '0;

        // Single request on requester 0.
        req = 3'b001;
        req_slave_sel = 6'b00_00_00;
        req_data = 24'h00_00_5A;
        serve(0, 0, 8'h5A, 4, 0, 0);
        req = '0;

        // Invalid target on requester 1, then requester 2 is next.
        req = 3'b110;
        req_slave_sel = 6'b10_11_00;
        req_data = 24'h44_77_00;
        serve(1, 3, 8'h77, 0, 0, 0);
        serve(2, 2, 8'h44, 1, 0, 0);
        req = '0;

        // Request dropped during WAIT still completes with one ack.
        req = 3'b001;
        req_slave_sel = 6'b00_00_00;
        req_data = 24'h00_00_99;
        serve(0, 0, 8'h99, 4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_no_reack", ack, 0);
            chk("drop_idle", busy, 0);
        end

        // Timeout with spi_done held low.
        req = 3'b001;
        req_data = 24'h00_00_C3;
        step();
        chk("tmo_start", spi_start, 1);
        n = 0;
        while (n < c_tmo + 10) begin
            step();
            n++;
            if (ack != 3'b000) break;
        end
        chk("tmo_latency", n, c_tmo + 1);
        chk("tmo_ack", ack, 3'b001);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_data", rsp_data, 0);
        req = '0;
        step();
        chk("tmo_busy_end", busy, 0);
        mptr = 1;

        // spi_done already high at ISSUE: only a fresh rising edge completes.
        req = 3'b100;
        req_slave_sel = 6'b10_00_00;
        req_data = 24'h5C_00_00;
        spi_done = 1'b1;
        step();
        chk("lvl_start", spi_start, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lvl_no_ack", ack, 0);
        end
        spi_done = 1'b0;
        step();
        chk("lvl_no_ack_low", ack, 0);
        spi_done = 1'b1;
        spi_miso_data = slave_tx[2];
        step();
        chk("lvl_ack", ack, 3'b100);
        chk("lvl_data", rsp_data, slave_tx[2]);
        spi_done = 1'b0;
        req = '0;
        step();
        chk("lvl_busy_end", busy, 0);
        mptr = 0;

        // Asynchronous reset while waiting on slave 1.
        req = 3'b010;
        req_slave_sel = 6'b00_01_00;
        req_data = 24'h00_6B_00;
        step();
        chk("rstw_start", spi_start, 1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rstw_gnt", gnt, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_start0", spi_start, 0);
        req = '0;
        spi_done = 1'b1;
        spi_miso_data = slave_tx[1];
        step();
        chk("rstw_no_ack", ack, 0);
        spi_done = 1'b0;
        step();
        chk("rstw_no_ack2", ack, 0);
        rst = 1'b0;
        mptr = 0;
        req = 3'b100;
        req_slave_sel = 6'b10_00_00;
        req_data = 24'h77_00_00;
        serve(2, 2, 8'h77, 2, 0, 0);
        req = '0;

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 40; it++) begin
            r   = 3'($urandom_range(1, 7));
            s   = 6'($urandom);
            dat = 24'($urandom);
            req = r;
            req_slave_sel = s;
            req_data = dat;
            idx = rr_pick(r, mptr);
            serve(idx, int'(s[2*idx +: 2]), dat[8*idx +: 8], $urandom_range(0, 6), 0, 1);
        end
        req = '0;
        step();
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
